arb_wrr_burst: RTL

- Weighted round-robin arbiter with burst hold. Shares one downstream resource (bus or port) among N requesters.
- Each grant is held for up to a per-requester number of beats (weight), or until the grantee signals last beat.
- Rotating priority moves past the last grantee on every release.
- Sits between the requester bank and the shared resource; the resource's beat handshake drives burst accounting.

---
 rtl/arb_wrr_burst.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/arb_wrr_burst.sv
// Weighted round-robin arbiter with burst hold and optional watchdog.
// Optional feature macro: ARB_TIMEOUT_EN (idle-beat release after TO_CYC).
module arb_wrr_burst #(
  parameter int N      = 4,
  parameter int IW     = 2,
  parameter int WW     = 4,
  parameter int TO_CYC = 64
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [N-1:0]    i_req,
  input  logic [N*WW-1:0] i_weight,
  input  logic            i_beat,
  input  logic            i_last,
  output logic [N-1:0]    o_gnt,
  output logic [IW-1:0]   o_gnt_id,
  output logic            o_busy,
  output logic            o_timeout
);

  if (IW != $clog2(N)) begin : g_bad_iw
    $error("IW must equal clog2(N)");
  end
  if (TO_CYC < 1) begin : g_bad_to
    $error("TO_CYC must be at least 1");
  end

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [N-1:0]   gnt_nx;
  logic [IW-1:0]  gnt_id_nx;
  logic           busy_nx;
  logic           timeout_nx;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  ptr_nx;
  logic [IW-1:0]  ptr_after;
  logic [WW-1:0]  credit;
  logic [WW-1:0]  credit_nx;

  logic [IW-1:0]  scan_base;
  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [IW-1:0]  off;
  logic [IW:0]    win_sum;
  logic [IW-1:0]  win;
  logic           found;
  logic [WW-1:0]  win_weight;

  logic in_grant;
  logic drop;
  logic spend;
  logic done;
  logic to_hit;
  logic rel;
  logic issue;

  // Burst accounting: drop wins over a same-cycle beat
  always_comb begin
    in_grant = (state == S_GRANT);
    drop     = in_grant && ~|(i_req & o_gnt);
    spend    = in_grant && !drop && i_beat;
    done     = spend && ((credit == WW'(1)) || i_last);
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);

  logic [TW-1:0] wd;
  logic [TW-1:0] wd_nx;

  // Watchdog next value: cleared by grant issue or any beat
  always_comb begin
    to_hit = in_grant && !drop && !i_beat &&
             (wd == TW'(TO_CYC - 1));
    wd_nx  = wd;
    if (issue || (in_grant && i_beat)) begin
      wd_nx = '0;
    end else if (in_grant) begin
      wd_nx = wd + TW'(1);
    end
  end

  // Watchdog counter register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wd <= '0;
    end else begin
      wd <= wd_nx;
    end
  end
`else
  // No watchdog: a stalled grantee keeps the grant
  always_comb begin
    to_hit = 1'b0;
  end
`endif

  // Release decision and the pointer it would leave behind
  always_comb begin
    rel = drop || done || to_hit;
    if (o_gnt_id == IW'(N - 1)) begin
      ptr_after = '0;
    end else begin
      ptr_after = o_gnt_id + IW'(1);
    end
    scan_base = in_grant ? ptr_after : ptr;
  end

  // Rotating priority scan starting at scan_base
  always_comb begin
    req_dbl = {i_req, i_req} >> scan_base;
    req_rot = req_dbl[N-1:0];
    off     = '0;
    found   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        off   = IW'(i);
        found = 1'b1;
      end
    end
    win_sum = {1'b0, scan_base} + {1'b0, off};
    if (win_sum >= (IW + 1)'(N)) begin
      win_sum = win_sum - (IW + 1)'(N);
    end
    win = win_sum[IW-1:0];
  end

  // Winner's credit, zero weight promoted to one
  always_comb begin
    win_weight = '0;
    for (int k = 0; k < N; k++) begin
      if (IW'(k) == win) begin
        win_weight = i_weight[k*WW +: WW];
      end
    end
    if (win_weight == '0) begin
      win_weight = WW'(1);
    end
    issue = found && (!in_grant || rel);
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (found) begin
          state_nx = S_GRANT;
        end
      end
      S_GRANT: begin
        if (rel && !found) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM outputs: grant, pointer and credit next values
  always_comb begin
    gnt_nx     = o_gnt;
    gnt_id_nx  = o_gnt_id;
    busy_nx    = o_busy;
    ptr_nx     = ptr;
    credit_nx  = credit;
    timeout_nx = to_hit;
    if (in_grant && rel) begin
      ptr_nx    = ptr_after;
      gnt_nx    = '0;
      busy_nx   = 1'b0;
      credit_nx = '0;
    end else if (spend) begin
      if (credit != '0) begin
        credit_nx = credit - WW'(1);
      end
    end
    if (issue) begin
      for (int k = 0; k < N; k++) begin
        gnt_nx[k] = (IW'(k) == win);
      end
      gnt_id_nx = win;
      busy_nx   = 1'b1;
      credit_nx = win_weight;
    end
  end

  // Registered outputs and arbitration state
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_gnt     <= '0;
      o_gnt_id  <= '0;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
      ptr       <= '0;
      credit    <= '0;
    end else begin
      o_gnt     <= gnt_nx;
      o_gnt_id  <= gnt_id_nx;
      o_busy    <= busy_nx;
      o_timeout <= timeout_nx;
      ptr       <= ptr_nx;
      credit    <= credit_nx;
    end
  end

endmodule
